lfsr_prbs_gen: RTL and testbench
================================

LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, state register width; legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 16'hB400, feedback tap mask [WIDTH-1:0].
REQ-003 SHALL have parameter MODE, default LFSR_FIB, either LFSR_FIB or LFSR_GAL.
REQ-004 SHALL have parameter STEP, default 1, PRBS bits produced per enabled cycle; legal range 1..WIDTH.
REQ-005 SHALL have parameter SEED, default 16'hA2C1, reset and recovery state; SHALL be non-zero.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 nrst  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  advance the LFSR by STEP sub-steps this cycle.
REQ-009 load  input  1  load seed_in as the new state and reference seed.
REQ-010 seed_in  input  WIDTH  seed value, sampled only when load=1.
REQ-011 dout  output  STEP  PRBS bits of the last advance; dout[0] is the oldest bit.
REQ-012 vld  output  1  dout is new this cycle.
REQ-013 state  output  WIDTH  current LFSR state register.
REQ-014 wrap  output  1  one-cycle pulse: the state has returned to the reference seed.
REQ-015 lockup  output  1  one-cycle pulse: a zero seed was rejected.

Function
REQ-016 One sub-step in Fibonacci mode: out bit = s[0]; fb = XOR-reduce(s & TAPS); next = {fb, s[WIDTH-1:1]}.
REQ-017 One sub-step in Galois mode: out bit = s[0]; next = (s >> 1) XOR (s[0] ? TAPS : 0).
REQ-018 When en=1 and load=0, state SHALL advance STEP chained sub-steps in one clock, and dout[k] SHALL be the out bit of sub-step k.
REQ-019 dout and vld SHALL be registered, with one-clock latency from the en edge; when en=0, vld=0 and dout holds its value.
REQ-020 When en=0 and load=0, state SHALL hold.
REQ-021 load SHALL have priority over en: state := seed_in, reference seed := seed_in, no advance, vld=0.
REQ-022 A load with seed_in == 0 SHALL instead load SEED into both state and reference seed, and SHALL pulse lockup for one cycle.
REQ-023 The state register SHALL never hold all-zeros.
REQ-024 wrap SHALL pulse in the cycle after an advance whose final state equals the reference seed.
REQ-025 For STEP > 1, wrap SHALL fire only when the post-advance state matches the reference seed; intermediate sub-step states are not compared.
REQ-026 The feedback and shift arithmetic SHALL be purely bitwise with no carries; all widths SHALL be exactly WIDTH.
REQ-027 Elaboration SHALL fail when WIDTH, STEP, TAPS == 0, or SEED == 0 is out of range.

Reset
REQ-028 While nrst=0: state = SEED, reference seed = SEED, dout = 0, vld = 0, wrap = 0, lockup = 0.
REQ-029 Reset asserted mid-advance SHALL discard the advance immediately, with no partial update.
REQ-030 After release, the first en cycle SHALL produce the same dout as the first en cycle after power-up.

Structure
REQ-031 Package lfsr_pkg SHALL hold the lfsr_mode_e enum (LFSR_FIB, LFSR_GAL) and the default TAPS/SEED constants for widths 4, 8, 16 and 32.
REQ-032 Sub-module lfsr_step SHALL be purely combinational, compute one sub-step (state in -> state out, out bit), be parameterised by WIDTH, TAPS and MODE, and be instantiated STEP times in a chain.

Verification
REQ-033 WIDTH=4, TAPS=4'b1001, FIB, STEP=1: load 4'b0001, then en for 15 cycles -> state sequence 1000,1100,1110,1111,0111,1011,0101,1010,1101,0110,0011,1001,0100,0010,0001; dout bits 1,0,0,0,1,1,1,1,0,1,0,1,1,0,0; wrap pulses once, after the 15th advance.
REQ-034 Same configuration with STEP=3: 5 enabled cycles -> dout = the same 15 bits in groups of three with dout[0] first; final state 0001 and wrap pulses.
REQ-035 load with seed_in=0 -> state = SEED, lockup=1 for exactly one cycle, vld=0; the next advance proceeds from SEED.
REQ-036 load=1 and en=1 in the same cycle -> state = seed_in, no dout update, vld=0.
REQ-037 Default configuration, nrst pulsed low after 100 advances -> state = 16'hA2C1 asynchronously, and the first 32 bits after release match the first 32 bits after power-up.
REQ-038 Galois, WIDTH=16, TAPS=16'hB400, seed 1, 65535 advances -> no zero state, and exactly one wrap pulse, at advance 65535.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default polynomial/seed constants for the LFSR PRBS generator.
package lfsr_pkg;

    typedef enum logic [0:0] {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam logic [3:0]  LFSR_TAPS_4  = 4'b1001;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'hA300_0000;

    localparam logic [3:0]  LFSR_SEED_4  = 4'h1;
    localparam logic [7:0]  LFSR_SEED_8  = 8'h5A;
    localparam logic [15:0] LFSR_SEED_16 = 16'hA2C1;
    localparam logic [31:0] LFSR_SEED_32 = 32'h1D87_2B41;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR sub-step: emits s_in[0] and produces the shifted state.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
    parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] s_in,
    output logic [WIDTH-1:0] s_out,
    output logic             out_bit
);

    always_comb begin
        out_bit = s_in[0];
        if (MODE == LFSR_FIB) begin
            s_out = {^(s_in & TAPS), s_in[WIDTH-1:1]};
        end else begin
            s_out = (s_in >> 1) ^ (s_in[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS generator: STEP chained LFSR sub-steps per enabled cycle, with seed load,
// zero-seed rejection and wrap detection against the most recently loaded seed.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
    parameter lfsr_mode_e       MODE  = LFSR_FIB,
    parameter int               STEP  = 1,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [STEP-1:0]  dout,
    output logic             vld,
    output logic [WIDTH-1:0] state,
    output logic             wrap,
    output logic             lockup
);

    if (WIDTH < 3 || WIDTH > 32 || STEP < 1 || STEP > WIDTH || TAPS == '0 || SEED == '0)
    begin : g_bad_cfg
        $fatal(1, "lfsr_prbs_gen: illegal WIDTH/STEP/TAPS/SEED");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [STEP-1:0]  dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] chain [STEP+1];
    logic [STEP-1:0]  adv_bits;

    assign chain[0] = state_q;

    for (genvar k = 0; k < STEP; k++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .MODE  (MODE)
        ) u_step (
            .s_in    (chain[k]),
            .s_out   (chain[k+1]),
            .out_bit (adv_bits[k])
        );
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        ref_d    = ref_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            if (seed_in == '0) begin
                state_d  = SEED;
                ref_d    = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = seed_in;
                ref_d   = seed_in;
            end
        end else if (en) begin
            // A degenerate tap mask could collapse to zero; fall back to SEED instead.
            state_d = (chain[STEP] == '0) ? SEED : chain[STEP];
            dout_d  = adv_bits;
            vld_d   = 1'b1;
            wrap_d  = (state_d == ref_q);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign state  = state_q;
    assign dout   = dout_q;
    assign vld    = vld_q;
    assign wrap   = wrap_q;
    assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench: 4-bit Fibonacci (STEP 1 and 3), default-config reset replay,
// and a full-period 16-bit Galois run.
module tb_lfsr_prbs_gen;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: WIDTH 4, FIB, STEP 1
    logic       nrst;
    logic       en_a, load_a;
    logic [3:0] seed_a, state_a;
    logic [0:0] dout_a;
    logic       vld_a, wrap_a, lockup_a;
    // Instance b: WIDTH 4, FIB, STEP 3
    logic       en_b, load_b;
    logic [3:0] seed_b, state_b;
    logic [2:0] dout_b;
    logic       vld_b, wrap_b, lockup_b;
    // Instance c: default configuration, own reset
    logic        nrst_c, en_c, load_c;
    logic [15:0] seed_c, state_c;
    logic [0:0]  dout_c;
    logic        vld_c, wrap_c, lockup_c;
    // Instance d: WIDTH 16, Galois, TAPS B400
    logic        en_d, load_d;
    logic [15:0] seed_d, state_d;
    logic [0:0]  dout_d;
    logic        vld_d, wrap_d, lockup_d;

    lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(LFSR_FIB), .STEP(1), .SEED(4'h1)) u_a (
        .clk(clk), .nrst(nrst), .en(en_a), .load(load_a), .seed_in(seed_a),
        .dout(dout_a), .vld(vld_a), .state(state_a), .wrap(wrap_a), .lockup(lockup_a));

    lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(LFSR_FIB), .STEP(3), .SEED(4'h1)) u_b (
        .clk(clk), .nrst(nrst), .en(en_b), .load(load_b), .seed_in(seed_b),
        .dout(dout_b), .vld(vld_b), .state(state_b), .wrap(wrap_b), .lockup(lockup_b));

    lfsr_prbs_gen u_c (
        .clk(clk), .nrst(nrst_c), .en(en_c), .load(load_c), .seed_in(seed_c),
        .dout(dout_c), .vld(vld_c), .state(state_c), .wrap(wrap_c), .lockup(lockup_c));

    lfsr_prbs_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(LFSR_GAL), .STEP(1), .SEED(16'hA2C1)) u_d (
        .clk(clk), .nrst(nrst), .en(en_d), .load(load_d), .seed_in(seed_d),
        .dout(dout_d), .vld(vld_d), .state(state_d), .wrap(wrap_d), .lockup(lockup_d));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Fibonacci stream for the default configuration, built from the polynomial.
    function automatic logic [31:0] fib16_bits(input logic [15:0] seed);
        logic [15:0] s;
        logic [31:0] b;
        s = seed;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = s[0];
            s    = {^(s & 16'hB400), s[15:1]};
        end
        return b;
    endfunction

    // Hand-computed 4-bit sequence from seed 0001 with taps 1001
    logic [3:0] exp_state [15] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                                   4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b0110,
                                   4'b0011, 4'b1001, 4'b0100, 4'b0010, 4'b0001};
    logic       exp_bit   [15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_grp   [5]  = '{3'b001, 3'b110, 3'b011, 3'b101, 3'b001};
    logic [3:0] exp_gst   [5]  = '{4'b1110, 4'b1011, 4'b1101, 4'b1001, 4'b0001};

    initial begin
        logic [31:0] ref_bits, pw_bits, rs_bits;
        int wrap_cnt, wrap_at, zero_cnt;

        nrst = 1'b0; nrst_c = 1'b0;
        en_a = 0; load_a = 0; seed_a = '0;
        en_b = 0; load_b = 0; seed_b = '0;
        en_c = 0; load_c = 0; seed_c = '0;
        en_d = 0; load_d = 0; seed_d = '0;
        #12;
        check("rst_state_a",  state_a, 4'h1);
        check("rst_dout_a",   dout_a, 0);
        check("rst_vld_a",    vld_a, 0);
        check("rst_wrap_a",   wrap_a, 0);
        check("rst_lockup_a", lockup_a, 0);
        check("rst_state_c",  state_c, 16'hA2C1);
        @(negedge clk);
        nrst = 1'b1; nrst_c = 1'b1;

        // Fibonacci STEP=1: full period from 0001
        load_a = 1; seed_a = 4'b0001;
        tick();
        load_a = 0;
        check("load_state_a", state_a, 4'b0001);
        check("load_vld_a",   vld_a, 0);
        en_a = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("fib1_state[%0d]", i), state_a, exp_state[i]);
            check($sformatf("fib1_dout[%0d]", i),  dout_a, exp_bit[i]);
            check($sformatf("fib1_vld[%0d]", i),   vld_a, 1);
            check($sformatf("fib1_wrap[%0d]", i),  wrap_a, (i == 14) ? 1 : 0);
        end
        tick();
        check("past_wrap_state", state_a, 4'b1000);
        check("past_wrap_dout",  dout_a, 1);
        check("past_wrap_wrap",  wrap_a, 0);

        // en low: hold state and dout, no vld
        en_a = 0;
        tick();
        check("hold_state", state_a, 4'b1000);
        check("hold_dout",  dout_a, 1);
        check("hold_vld",   vld_a, 0);

        // load has priority over en
        en_a = 1; load_a = 1; seed_a = 4'b0110;
        tick();
        check("ldpri_state", state_a, 4'b0110);
        check("ldpri_vld",   vld_a, 0);
        check("ldpri_dout",  dout_a, 1);

        // zero seed is rejected in favour of SEED
        en_a = 0; seed_a = 4'b0000;
        tick();
        load_a = 0; en_a = 1;
        check("zero_state",  state_a, 4'b0001);
        check("zero_lockup", lockup_a, 1);
        check("zero_vld",    vld_a, 0);
        tick();
        en_a = 0;
        check("zero_lockup_gone", lockup_a, 0);
        check("zero_next_state",  state_a, 4'b1000);
        check("zero_next_dout",   dout_a, 1);
        check("zero_next_vld",    vld_a, 1);

        // Fibonacci STEP=3: same stream in 3-bit groups
        load_b = 1; seed_b = 4'b0001;
        tick();
        load_b = 0; en_b = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fib3_dout[%0d]", i),  dout_b, exp_grp[i]);
            check($sformatf("fib3_state[%0d]", i), state_b, exp_gst[i]);
            check($sformatf("fib3_wrap[%0d]", i),  wrap_b, (i == 4) ? 1 : 0);
        end
        en_b = 0;

        // Default config: 100 advances, async reset mid-run, replay first 32 bits
        ref_bits = fib16_bits(16'hA2C1);
        pw_bits  = '0;
        rs_bits  = '0;
        en_c = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i < 32) pw_bits[i] = dout_c[0];
        end
        check("pwrup_bits", pw_bits, ref_bits);
        #2 nrst_c = 1'b0;
        #1;
        check("async_rst_state", state_c, 16'hA2C1);
        check("async_rst_vld",   vld_c, 0);
        check("async_rst_dout",  dout_c, 0);
        en_c = 0;
        @(negedge clk);
        nrst_c = 1'b1;
        en_c = 1;
        for (int i = 0; i < 32; i++) begin
            tick();
            rs_bits[i] = dout_c[0];
        end
        en_c = 0;
        check("replay_bits", rs_bits, ref_bits);

        // Galois full period from seed 1
        load_d = 1; seed_d = 16'h0001;
        tick();
        load_d = 0; en_d = 1;
        wrap_cnt = 0; wrap_at = 0; zero_cnt = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (state_d == 16'h0000) zero_cnt++;
            if (wrap_d) begin
                wrap_cnt++;
                wrap_at = i;
            end
        end
        en_d = 0;
        check("gal_zero_states", zero_cnt, 0);
        check("gal_wrap_count",  wrap_cnt, 1);
        check("gal_wrap_at",     wrap_at, 65535);
        check("gal_final_state", state_d, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
